instr_fetch_router: RTL and testbench
=====================================

INSTR_FETCH_ROUTER -- requirements
Module: instr_fetch_router

Interface
REQ-001 SHALL have parameter RamBase, default 32'h00100000, RAM region base address.
REQ-002 SHALL have parameter RamMask, default 32'hFFFF0000, RAM region mask (64 KiB).
REQ-003 SHALL have parameter DbgBase, default 32'h1a110000, debug-memory region base address.
REQ-004 SHALL have parameter DbgMask, default 32'hFFFF0000, debug-memory region mask.
REQ-005 SHALL have parameter DbgEn, default 1, enabling the debug region; when 0 the debug region decodes as unmapped.
REQ-006 SHALL have port clk_sys_i  input  1  system clock, all state on rising edge.
REQ-007 SHALL have port rst_sys_ni  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports instr_req_i/instr_addr_i  input  1/32  core fetch request and word address.
REQ-009 SHALL have ports instr_gnt_o/instr_rvalid_o/instr_err_o  output  1/1/1  core grant, response valid, response error.
REQ-010 SHALL have port instr_rdata_o  output  32  core fetch data.
REQ-011 SHALL have ports ram_req_o/ram_addr_o  output  1/32  RAM fetch port request and address; ram_rdata_i  input  32, valid exactly 1 cycle after ram_req_o.
REQ-012 SHALL have ports dbg_req_o/dbg_addr_o  output  1/32  debug-memory fetch request and address; dbg_rdata_i  input  32, valid 1 cycle after dbg_req_o.
REQ-013 SHALL have port dbg_busy_i  input  1  debug memory claimed this cycle by the data-side bus.
REQ-014 SHALL have ports err_count_o  output  8  saturating unmapped-fetch count; err_addr_o  output  32  address of most recent unmapped fetch.

Function
REQ-015 SHALL decode instr_addr_i each cycle: RAM if (addr & RamMask)==RamBase, else DBG if DbgEn and (addr & DbgMask)==DbgBase, else ERR; RAM wins on overlap.
REQ-016 SHALL assert ram_req_o = instr_req_i & RAM, ram_addr_o = instr_addr_i, combinationally.
REQ-017 SHALL assert dbg_req_o = instr_req_i & DBG & ~dbg_busy_i, dbg_addr_o = instr_addr_i.
REQ-018 SHALL assert instr_gnt_o = instr_req_i & (RAM | ERR | (DBG & ~dbg_busy_i)); DBG requests stall with gnt low while dbg_busy_i high, request held by core.
REQ-019 SHALL register per granted request a response tag (target enum) and assert instr_rvalid_o exactly 1 cycle after each grant; back-to-back grants give back-to-back rvalids.
REQ-020 SHALL drive instr_rdata_o from ram_rdata_i for RAM tag, dbg_rdata_i for DBG tag, 32'h0 for ERR tag; instr_err_o=1 only with ERR tag and rvalid.
REQ-021 SHALL, when rvalid low, drive instr_rdata_o=0 and instr_err_o=0.
REQ-022 SHALL on each granted ERR request capture instr_addr_i into err_addr_o and increment err_count_o, holding at 8'hFF (no wrap).
REQ-023 SHALL never produce a response without a prior grant, nor more than one outstanding response.

Reset
REQ-024 SHALL on rst_sys_ni low clear tag valid, instr_rvalid_o=0, instr_err_o=0, err_count_o=0, err_addr_o=0; combinational outputs follow inputs.
REQ-025 SHALL, on reset asserted mid-transaction, discard the pending response; no rvalid after deassertion until a new grant.

Structure
REQ-026 SHALL place the target enum (TgtRam, TgtDbg, TgtErr) and default base/mask constants in shared package instr_fetch_pkg.
REQ-027 SHALL isolate decode in combinational sub-module instr_addr_decode; tag register, counters and response mux reside in instr_fetch_router.

Verification
REQ-028 SHALL test: req at 0x00100080 with ram_rdata_i=0xDEADBEEF next cycle -> gnt same cycle, rvalid+rdata 0xDEADBEEF one cycle later, err=0.
REQ-029 SHALL test: three back-to-back RAM fetches 0x00100000/04/08 -> three consecutive rvalids in order with matching data.
REQ-030 SHALL test: DBG fetch 0x1a110800 with dbg_busy_i high 3 cycles -> gnt and dbg_req_o low 3 cycles, grant cycle 4, rvalid cycle 5 with dbg_rdata_i.
REQ-031 SHALL test: fetch 0x40000000 -> gnt, rvalid with err=1, rdata 0, err_addr_o=0x40000000, err_count_o=1; 300 such fetches -> err_count_o=0xFF.
REQ-032 SHALL test: DbgEn=0, fetch 0x1a110000 -> error response; reset asserted the cycle after a RAM grant -> no rvalid after reset release.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types and default address map for the instruction fetch router.
package instr_fetch_pkg;

  localparam int unsigned AddrW   = 32;
  localparam int unsigned DataW   = 32;
  localparam int unsigned ErrCntW = 8;

  localparam logic [AddrW-1:0] RamBaseDflt = 32'h0010_0000;
  localparam logic [AddrW-1:0] RamMaskDflt = 32'hFFFF_0000;
  localparam logic [AddrW-1:0] DbgBaseDflt = 32'h1a11_0000;
  localparam logic [AddrW-1:0] DbgMaskDflt = 32'hFFFF_0000;

  typedef enum logic [1:0] {
    TgtRam = 2'd0,
    TgtDbg = 2'd1,
    TgtErr = 2'd2
  } tgt_e;

  // Tag of the single outstanding response
  typedef struct packed {
    logic valid;
    tgt_e tgt;
  } rsp_tag_t;

endpackage

// File: rtl/instr_addr_decode.sv
// Combinational fetch-address decode into RAM, debug memory or unmapped.
module instr_addr_decode
  import instr_fetch_pkg::*;
#(
  parameter logic [AddrW-1:0] RamBase = RamBaseDflt,
  parameter logic [AddrW-1:0] RamMask = RamMaskDflt,
  parameter logic [AddrW-1:0] DbgBase = DbgBaseDflt,
  parameter logic [AddrW-1:0] DbgMask = DbgMaskDflt,
  parameter bit               DbgEn   = 1'b1
) (
  input  logic [AddrW-1:0] addr_i,
  output tgt_e             tgt_o
);

  logic hit_ram;
  logic hit_dbg;

  // RAM takes priority where the two regions overlap
  always_comb begin
    hit_ram = ((addr_i & RamMask) == RamBase);
    hit_dbg = DbgEn && ((addr_i & DbgMask) == DbgBase);
    tgt_o   = TgtErr;
    if (hit_ram) begin
      tgt_o = TgtRam;
    end else if (hit_dbg) begin
      tgt_o = TgtDbg;
    end
  end

endmodule

// File: rtl/instr_fetch_router.sv
// Routes core instruction fetches to RAM or debug memory and answers unmapped
// fetches with an error response; one response per grant, one cycle later.
module instr_fetch_router
  import instr_fetch_pkg::*;
#(
  parameter logic [AddrW-1:0] RamBase = RamBaseDflt,
  parameter logic [AddrW-1:0] RamMask = RamMaskDflt,
  parameter logic [AddrW-1:0] DbgBase = DbgBaseDflt,
  parameter logic [AddrW-1:0] DbgMask = DbgMaskDflt,
  parameter bit               DbgEn   = 1'b1
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_sys_ni,
  input  logic                 instr_req_i,
  input  logic [AddrW-1:0]     instr_addr_i,
  output logic                 instr_gnt_o,
  output logic                 instr_rvalid_o,
  output logic                 instr_err_o,
  output logic [DataW-1:0]     instr_rdata_o,
  output logic                 ram_req_o,
  output logic [AddrW-1:0]     ram_addr_o,
  input  logic [DataW-1:0]     ram_rdata_i,
  output logic                 dbg_req_o,
  output logic [AddrW-1:0]     dbg_addr_o,
  input  logic [DataW-1:0]     dbg_rdata_i,
  input  logic                 dbg_busy_i,
  output logic [ErrCntW-1:0]   err_count_o,
  output logic [AddrW-1:0]     err_addr_o
);

  localparam logic [ErrCntW-1:0] ErrCntMax = '1;

  tgt_e             tgt;
  logic             is_ram;
  logic             is_dbg;
  logic             is_err;
  logic             err_gnt;

  rsp_tag_t         tag_q,     tag_d;
  logic [ErrCntW-1:0] err_cnt_q, err_cnt_d;
  logic [AddrW-1:0] err_addr_q, err_addr_d;

  instr_addr_decode #(
    .RamBase (RamBase),
    .RamMask (RamMask),
    .DbgBase (DbgBase),
    .DbgMask (DbgMask),
    .DbgEn   (DbgEn)
  ) u_decode (
    .addr_i (instr_addr_i),
    .tgt_o  (tgt)
  );

  // Request routing; debug fetches stall while the data side owns the memory
  always_comb begin
    is_ram      = (tgt == TgtRam);
    is_dbg      = (tgt == TgtDbg);
    is_err      = (tgt == TgtErr);
    ram_req_o   = instr_req_i & is_ram;
    ram_addr_o  = instr_addr_i;
    dbg_req_o   = instr_req_i & is_dbg & ~dbg_busy_i;
    dbg_addr_o  = instr_addr_i;
    instr_gnt_o = instr_req_i & (is_ram | is_err | (is_dbg & ~dbg_busy_i));
    err_gnt     = instr_gnt_o & is_err;
  end

  // Response tag and unmapped-fetch bookkeeping
  always_comb begin
    tag_d.valid = instr_gnt_o;
    tag_d.tgt   = tgt;
    err_cnt_d   = err_cnt_q;
    err_addr_d  = err_addr_q;
    if (err_gnt) begin
      err_addr_d = instr_addr_i;
      if (err_cnt_q != ErrCntMax) begin
        err_cnt_d = err_cnt_q + ErrCntW'(1);
      end
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      tag_q      <= '{valid: 1'b0, tgt: TgtRam};
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      tag_q      <= tag_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Response mux: data arrives from the target one cycle after its request
  always_comb begin
    instr_rvalid_o = tag_q.valid;
    instr_err_o    = 1'b0;
    instr_rdata_o  = '0;
    if (tag_q.valid) begin
      case (tag_q.tgt)
        TgtRam:  instr_rdata_o = ram_rdata_i;
        TgtDbg:  instr_rdata_o = dbg_rdata_i;
        default: instr_err_o   = 1'b1;
      endcase
    end
  end

  assign err_count_o = err_cnt_q;
  assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_instr_fetch_router.sv
// Scoreboard bench for instr_fetch_router: stimulus pushes expected responses,
// monitors pop and compare whenever a response is presented.
module tb_instr_fetch_router;
  import instr_fetch_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic        req     = 1'b0;
  logic        req2    = 1'b0;
  logic [31:0] addr    = '0;
  logic        busy    = 1'b0;
  logic [31:0] ram_rdata = '0;
  logic [31:0] dbg_rdata = '0;

  logic        gnt1, rvalid1, err1, ram_req1, dbg_req1;
  logic [31:0] rdata1, ram_addr1, dbg_addr1, err_addr1;
  logic [7:0]  err_cnt1;
  logic        gnt2, rvalid2, err2, ram_req2, dbg_req2;
  logic [31:0] rdata2, ram_addr2, dbg_addr2, err_addr2;
  logic [7:0]  err_cnt2;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t q1[$];
  exp_t q2[$];
  logic gp1 = 1'b0;
  logic gp2 = 1'b0;
  logic erv1, erv2;
  exp_t e1, e2;

  always #5 clk_sys = ~clk_sys;

  instr_fetch_router u_dut (
    .clk_sys_i (clk_sys), .rst_sys_ni (rst_n),
    .instr_req_i (req), .instr_addr_i (addr),
    .instr_gnt_o (gnt1), .instr_rvalid_o (rvalid1), .instr_err_o (err1),
    .instr_rdata_o (rdata1),
    .ram_req_o (ram_req1), .ram_addr_o (ram_addr1), .ram_rdata_i (ram_rdata),
    .dbg_req_o (dbg_req1), .dbg_addr_o (dbg_addr1), .dbg_rdata_i (dbg_rdata),
    .dbg_busy_i (busy),
    .err_count_o (err_cnt1), .err_addr_o (err_addr1)
  );

  instr_fetch_router #(.DbgEn(1'b0)) u_dut_nodbg (
    .clk_sys_i (clk_sys), .rst_sys_ni (rst_n),
    .instr_req_i (req2), .instr_addr_i (addr),
    .instr_gnt_o (gnt2), .instr_rvalid_o (rvalid2), .instr_err_o (err2),
    .instr_rdata_o (rdata2),
    .ram_req_o (ram_req2), .ram_addr_o (ram_addr2), .ram_rdata_i (ram_rdata),
    .dbg_req_o (dbg_req2), .dbg_addr_o (dbg_addr2), .dbg_rdata_i (dbg_rdata),
    .dbg_busy_i (busy),
    .err_count_o (err_cnt2), .err_addr_o (err_addr2)
  );

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    case (a)
      32'h0010_0080: return 32'hDEAD_BEEF;
      32'h0010_0000: return 32'h1111_1111;
      32'h0010_0004: return 32'h2222_2222;
      32'h0010_0008: return 32'h3333_3333;
      default:       return 32'hBADB_AD00;
    endcase
  endfunction

  function automatic logic [31:0] dbg_word(input logic [31:0] a);
    if (a == 32'h1a11_0800) return 32'hCAFE_F00D;
    return 32'h0BAD_0000;
  endfunction

  // Memories answer exactly one cycle after their request
  always @(posedge clk_sys) begin
    ram_rdata <= ram_req1 ? ram_word(ram_addr1) : 32'h0;
    dbg_rdata <= dbg_req1 ? dbg_word(dbg_addr1) : 32'h0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the default instance
  always @(negedge clk_sys) begin
    erv1 = gp1 && rst_n;
    if (rvalid1 || erv1) begin
      chk("rvalid_timing", 32'(rvalid1), 32'(erv1));
      if (rvalid1) begin
        if (q1.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL rsp_unexpected: got rvalid with rdata %h expected no response", rdata1);
        end else begin
          e1 = q1.pop_front();
          chk("rdata", rdata1, e1.data);
          chk("rsp_err", 32'(err1), 32'(e1.err));
        end
      end
    end else begin
      chk("idle_rdata", rdata1, 32'h0);
      chk("idle_err", 32'(err1), 32'h0);
    end
    gp1 = gnt1 && rst_n;
  end

  // Monitor for the instance without a debug region
  always @(negedge clk_sys) begin
    erv2 = gp2 && rst_n;
    if (rvalid2 || erv2) begin
      chk("nodbg_rvalid_timing", 32'(rvalid2), 32'(erv2));
      if (rvalid2) begin
        if (q2.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL nodbg_rsp_unexpected: got rvalid with rdata %h expected no response", rdata2);
        end else begin
          e2 = q2.pop_front();
          chk("nodbg_rdata", rdata2, e2.data);
          chk("nodbg_rsp_err", 32'(err2), 32'(e2.err));
        end
      end
    end
    gp2 = gnt2 && rst_n;
  end

  // Issue one fetch, hold it through any stall, push the expected response at grant
  task automatic fetch(input bit which, input logic [31:0] a, input tgt_e tgt,
                       input logic [31:0] exp_data, input int busy_cycles, input bit expect_rsp);
    int   stall = 0;
    bit   done  = 1'b0;
    exp_t e;
    addr = a;
    if (which) req2 = 1'b1; else req = 1'b1;
    busy = (busy_cycles > 0);
    while (!done) begin
      @(negedge clk_sys);
      if (stall < busy_cycles) begin
        chk("gnt_stall", 32'(gnt1), 32'h0);
        chk("dbg_req_stall", 32'(dbg_req1), 32'h0);
      end else begin
        if (which) begin
          chk("nodbg_gnt", 32'(gnt2), 32'h1);
        end else begin
          chk("gnt", 32'(gnt1), 32'h1);
          chk("ram_req", 32'(ram_req1), 32'(tgt == TgtRam));
          chk("dbg_req", 32'(dbg_req1), 32'(tgt == TgtDbg));
        end
        if (expect_rsp) begin
          e.data = exp_data;
          e.err  = (tgt == TgtErr);
          if (which) q2.push_back(e); else q1.push_back(e);
        end
        done = 1'b1;
      end
      @(posedge clk_sys); #1;
      stall++;
      busy = (stall < busy_cycles);
    end
  endtask

  task automatic idle(input int n);
    req  = 1'b0;
    req2 = 1'b0;
    busy = 1'b0;
    repeat (n) begin
      @(posedge clk_sys); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_rvalid", 32'(rvalid1), 32'h0);
    chk("rst_err", 32'(err1), 32'h0);
    chk("rst_err_count", 32'(err_cnt1), 32'h0);
    chk("rst_err_addr", err_addr1, 32'h0);
    @(negedge clk_sys);
    rst_n = 1'b1;
    idle(2);

    // Single RAM fetch
    fetch(1'b0, 32'h0010_0080, TgtRam, 32'hDEAD_BEEF, 0, 1'b1);
    idle(2);

    // Back-to-back RAM fetches
    fetch(1'b0, 32'h0010_0000, TgtRam, 32'h1111_1111, 0, 1'b1);
    fetch(1'b0, 32'h0010_0004, TgtRam, 32'h2222_2222, 0, 1'b1);
    fetch(1'b0, 32'h0010_0008, TgtRam, 32'h3333_3333, 0, 1'b1);
    idle(2);

    // Debug fetch stalled three cycles by the data side
    fetch(1'b0, 32'h1a11_0800, TgtDbg, 32'hCAFE_F00D, 3, 1'b1);
    idle(2);

    // Unmapped fetch
    fetch(1'b0, 32'h4000_0000, TgtErr, 32'h0, 0, 1'b1);
    chk("err_addr_1", err_addr1, 32'h4000_0000);
    chk("err_count_1", 32'(err_cnt1), 32'h1);
    idle(2);

    // Saturation of the unmapped-fetch counter
    for (int i = 0; i < 300; i++) begin
      fetch(1'b0, 32'h4000_0000 + 32'(i * 4), TgtErr, 32'h0, 0, 1'b1);
    end
    idle(1);
    chk("err_count_sat", 32'(err_cnt1), 32'h0000_00FF);
    chk("err_addr_last", err_addr1, 32'h4000_04AC);
    idle(2);

    // Debug base is a real target here, unmapped when the region is disabled
    fetch(1'b0, 32'h1a11_0000, TgtDbg, 32'h0BAD_0000, 0, 1'b1);
    idle(2);
    fetch(1'b1, 32'h1a11_0000, TgtErr, 32'h0, 0, 1'b1);
    idle(1);
    chk("nodbg_err_addr", err_addr2, 32'h1a11_0000);
    chk("nodbg_err_count", 32'(err_cnt2), 32'h1);
    idle(2);

    // Reset the cycle after a RAM grant discards the pending response
    fetch(1'b0, 32'h0010_0004, TgtRam, 32'h0, 0, 1'b0);
    req   = 1'b0;
    rst_n = 1'b0;
    idle(2);
    chk("mid_rst_err_count", 32'(err_cnt1), 32'h0);
    chk("mid_rst_err_addr", err_addr1, 32'h0);
    @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk_sys);
      chk("post_rst_rvalid", 32'(rvalid1), 32'h0);
    end
    idle(2);

    chk("q1_drained", 32'(q1.size()), 32'h0);
    chk("q2_drained", 32'(q2.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
